// File: rtl/exp_bit_sequencer.sv
// exp_bit_sequencer: MSB-first square-and-multiply op sequencer; optional EXP_SEQ_SKIP_LZ_EN skips leading zeros
module exp_bit_sequencer #(
  parameter int n = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [n-1:0]         key,
  output logic                 op_valid,
  output logic                 op_type,
  input  logic                 op_ready,
  input  logic                 op_done,
  output logic [$clog2(n)-1:0] bit_index,
  output logic [n:0]           op_count,
  output logic                 busy,
  output logic                 seq_done
);
  localparam int W = $clog2(n);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE_SQ  = 3'd1;
  localparam logic [2:0] WAIT_SQ   = 3'd2;
  localparam logic [2:0] ISSUE_MUL = 3'd3;
  localparam logic [2:0] WAIT_MUL  = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  logic [2:0]   state_q, state_d;
  logic [n-1:0] key_q, key_d;
  logic [W-1:0] idx_q, idx_d;
  logic [n:0]   cnt_q, cnt_d;
  logic         last;
  logic [2:0]   next_state;
  logic [W-1:0] next_idx;
  assign last       = idx_q == '0;
  assign next_state = last ? DONE : ISSUE_SQ;
  assign next_idx   = last ? idx_q : idx_q - 1'b1;
`ifdef EXP_SEQ_SKIP_LZ_EN
  logic [W-1:0] msb;
  // priority encoder: index of the highest set key bit, so the walk starts there
  always_comb begin
    msb = '0;
    for (int i = 0; i < n; i++) msb = key[i] ? W'(i) : msb;
  end
`endif
  // next-state: DONE behaves like IDLE so a new start is taken during the seq_done pulse
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          key_d = key;
          cnt_d = '0;
`ifdef EXP_SEQ_SKIP_LZ_EN
          idx_d   = msb;
          state_d = |key ? ISSUE_MUL : DONE;
`else
          idx_d   = W'(n - 1);
          state_d = ISSUE_SQ;
`endif
        end
      end
      ISSUE_SQ, ISSUE_MUL: if (op_ready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = state_q == ISSUE_SQ ? WAIT_SQ : WAIT_MUL;
      end
      WAIT_SQ: if (op_done) begin
        state_d = key_q[idx_q] ? ISSUE_MUL : next_state;
        idx_d   = key_q[idx_q] ? idx_q : next_idx;
      end
      WAIT_MUL: if (op_done) begin
        state_d = next_state;
        idx_d   = next_idx;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset aborting any sequence in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  assign op_valid  = state_q == ISSUE_SQ || state_q == ISSUE_MUL;
  assign op_type   = state_q == ISSUE_MUL;
  assign busy      = state_q inside {ISSUE_SQ, WAIT_SQ, ISSUE_MUL, WAIT_MUL};
  assign seq_done  = state_q == DONE;
  assign bit_index = idx_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_exp_bit_sequencer.sv
// tb_exp_bit_sequencer: directed checks of op order, handshakes, backpressure, ignores and reset abort
module tb_exp_bit_sequencer;
  logic       clk = 0;
  logic       reset, start, op_ready, op_done;
  logic [5:0] key;
  logic       op_valid, op_type, busy, seq_done;
  logic [2:0] bit_index;
  logic [6:0] op_count;
  int errors = 0;
  int checks = 0;
  string s_basic, s_zero, s_ones, s_msb;
  int i_basic, i_zero, i_ones, i_msb;

  exp_bit_sequencer #(.n(6)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready), .op_done(op_done),
    .bit_index(bit_index), .op_count(op_count), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic run_seq(input string name, input logic [5:0] k, input string exp,
                         input int first_idx, input bit stall, input bit spur, input bit abort);
    int cnt;
    bit stalled;
    logic m;
    stalled = 0;
    @(negedge clk);
    start = 1;
    key = k;
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== (exp.len() > 0)) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want %b", name, busy, exp.len() > 0);
    end
    for (int i = 0; i < exp.len(); i++) begin
      m = exp[i] == "M";
      cnt = 0;
      while (op_valid !== 1'b1 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (op_valid !== 1'b1 || cnt != 0) begin
        errors++;
        $display("FAIL %s op_valid[%0d]: got %b after %0d idle cycles want 1 immediately", name, i, op_valid, cnt);
        if (op_valid !== 1'b1) return;
      end
      checks++;
      if (op_type !== m) begin
        errors++;
        $display("FAIL %s op_type[%0d]: got %b want %b", name, i, op_type, m);
      end
      checks++;
      if (op_count !== 7'(i)) begin
        errors++;
        $display("FAIL %s op_count_before[%0d]: got %0d want %0d", name, i, op_count, i);
      end
      if (i == 0) begin
        checks++;
        if (bit_index !== 3'(first_idx)) begin
          errors++;
          $display("FAIL %s first_bit_index: got %0d want %0d", name, bit_index, first_idx);
        end
      end
      if (stall && m && !stalled) begin
        stalled = 1;
        op_ready = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if ({op_valid, op_type, op_count} !== {1'b1, 1'b1, 7'(i)}) begin
            errors++;
            $display("FAIL %s stall[%0d]: got valid=%b type=%b count=%0d want 1 1 %0d", name, c, op_valid, op_type, op_count, i);
          end
        end
        op_ready = 1;
      end
      if (spur && i == 0) begin
        start = 1;
        op_done = 1;
      end
      @(negedge clk);
      start = 0;
      op_done = 0;
      checks++;
      if ({op_valid, op_count} !== {1'b0, 7'(i + 1)}) begin
        errors++;
        $display("FAIL %s after_accept[%0d]: got valid=%b count=%0d want 0 %0d", name, i, op_valid, op_count, i + 1);
      end
      if (abort && m) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        checks++;
        if ({op_valid, op_type, bit_index, op_count, busy, seq_done} !== 14'd0) begin
          errors++;
          $display("FAIL %s abort_outputs: got v=%b t=%b idx=%0d cnt=%0d busy=%b done=%b want all 0", name, op_valid, op_type, bit_index, op_count, busy, seq_done);
        end
        @(negedge clk);
        checks++;
        if ({op_valid, busy, seq_done} !== 3'b000) begin
          errors++;
          $display("FAIL %s abort_idle: got v=%b busy=%b done=%b want 000", name, op_valid, busy, seq_done);
        end
        return;
      end
      @(negedge clk);
      @(negedge clk);
      op_done = 1;
      @(negedge clk);
      op_done = 0;
    end
    checks++;
    if ({seq_done, busy, op_count} !== {1'b1, 1'b0, 7'(exp.len())}) begin
      errors++;
      $display("FAIL %s completion: got done=%b busy=%b count=%0d want 1 0 %0d", name, seq_done, busy, op_count, exp.len());
    end
    @(negedge clk);
    checks++;
    if (seq_done !== 1'b0) begin
      errors++;
      $display("FAIL %s seq_done_single: got %b want 0", name, seq_done);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    start = 0;
    op_ready = 1;
    op_done = 0;
    key = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    checks++;
    if ({op_valid, op_type, bit_index, op_count, busy, seq_done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%b t=%b idx=%0d cnt=%0d busy=%b done=%b want all 0", op_valid, op_type, bit_index, op_count, busy, seq_done);
    end
    @(negedge clk);
    checks++;
    if ({op_valid, busy, seq_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got v=%b busy=%b done=%b want 000", op_valid, busy, seq_done);
    end
  endtask

  task automatic test_basic();
    run_seq("basic", 6'b001011, s_basic, i_basic, 0, 0, 0);
  endtask

  task automatic test_zero_key();
    run_seq("zero_key", 6'b000000, s_zero, i_zero, 0, 0, 0);
  endtask

  task automatic test_all_ones();
    run_seq("all_ones", 6'b111111, s_ones, i_ones, 0, 0, 0);
  endtask

  task automatic test_msb_only();
    run_seq("msb_only", 6'b100000, s_msb, i_msb, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_seq("backpressure", 6'b001011, s_basic, i_basic, 1, 0, 0);
  endtask

  task automatic test_ignore();
    run_seq("ignore", 6'b001011, s_basic, i_basic, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    run_seq("reset_mid", 6'b100000, s_msb, i_msb, 0, 0, 1);
    run_seq("after_reset", 6'b001011, s_basic, i_basic, 0, 0, 0);
  endtask

  initial begin
`ifdef EXP_SEQ_SKIP_LZ_EN
    s_basic = "MSSMSM";      i_basic = 3;
    s_zero  = "";            i_zero  = 0;
    s_ones  = "MSMSMSMSMSM"; i_ones  = 5;
    s_msb   = "MSSSSS";      i_msb   = 5;
`else
    s_basic = "SSSMSSMSM";    i_basic = 5;
    s_zero  = "SSSSSS";       i_zero  = 5;
    s_ones  = "SMSMSMSMSMSM"; i_ones  = 5;
    s_msb   = "SMSSSSS";      i_msb   = 5;
`endif
    test_reset();
    test_basic();
    test_zero_key();
    test_all_ones();
    test_msb_only();
    test_backpressure();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
